cheri_tsmap_ctrl: RTL and testbench
===================================

# cheri_tsmap_ctrl

Single-port controller for the revocation bitmap (TSMAP) SRAM, shared between the load-revocation pipeline and a software/allocator update port. Revocation lookups have absolute priority and fixed 1-cycle read latency (the lookup pipeline never stalls). Bit set/clear updates run as read-modify-write sequences in the idle slots between lookups. Results of an in-flight update are forwarded to any colliding lookup.

## Interface
Parameters:
- TSMapSize, 1024: number of valid 32-bit TSMAP words; legal word addresses 0..TSMapSize-1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- trvk_cs_i  in  1  lookup read strobe (revocation pipeline)
- trvk_addr_i  in  16  lookup word address
- trvk_rdata_o  out  32  lookup data, valid the cycle after trvk_cs_i
- upd_req_i  in  1  update request, held until granted
- upd_gnt_o  out  1  update accepted (combinational)
- upd_addr_i  in  16  update word address
- upd_mask_i  in  32  bits to modify
- upd_set_i  in  1  1 = set masked bits, 0 = clear masked bits
- upd_done_o  out  1  1-cycle completion pulse
- upd_err_o  out  1  qualifies upd_done_o: address out of range
- busy_o  out  1  update in progress (state != IDLE)
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  16  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, 1 cycle after a read

## Operation
- FSM states: IDLE, RD, CAP, WR.
- IDLE:
  - upd_gnt_o = upd_req_i.
  - On grant, latch addr, mask and set.
  - In-range address -> RD.
  - Out-of-range address (upd_addr_i >= TSMapSize) -> stay IDLE; done+err pulse next cycle; no SRAM access.
- RD: if ~trvk_cs_i, issue the SRAM read of the latched address -> CAP. Otherwise hold in RD.
- CAP:
  - Capture mem_rdata_i.
  - Compute merged = set ? old|mask : old&~mask and store it in fwd_data_q.
  - -> WR.
- WR: if ~trvk_cs_i, write fwd_data_q to the latched address -> IDLE; done pulse next cycle, err=0. Otherwise hold in WR.
- A mask of 0 still performs the full RMW and writes back unchanged data.
- SRAM port mux:
  - trvk_cs_i drives mem_req_o=1, mem_we_o=0, mem_addr_o=trvk_addr_i.
  - Otherwise the FSM drives the port in RD/WR.
  - Otherwise mem_req_o=0.
- Forwarding:
  - Condition: trvk_cs_i in state CAP or WR with trvk_addr_i equal to the latched address.
  - Action: set fwd_sel_q for one cycle; trvk_rdata_o = fwd_sel_q ? merged value : mem_rdata_i.
  - In CAP the merged value is computed combinationally from the same-cycle mem_rdata_i.
  - A lookup colliding while in RD returns pre-update memory (the update has not been observed yet); this is correct.
- Updates may be deferred indefinitely under continuous trvk_cs_i. busy_o exposes this.

## Timing
- Reset values:
  - State IDLE.
  - upd_gnt_o = upd_req_i, as combinational in IDLE.
  - upd_done_o=0, upd_err_o=0, busy_o=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - fwd_sel_q=0; trvk_rdata_o=mem_rdata_i.
- Lookup: strobe at t, data at t+1, always, with no stall path.
- Update, uncontended: grant t, read t+1, capture t+2, write t+3, done t+4.
  - Each cycle of trvk_cs_i in RD or WR adds one cycle.
- Out-of-range update: grant t, done+err t+1.
- Next grant is possible in the same cycle done pulses, since the FSM is already in IDLE.
- Reset mid-update: abort immediately. No write, no done; the update is lost and the requester must retry.

## Structure
- Shared cheri_pkg holds the FSM state enum tsmap_ctrl_state_e and a function tsmap_merge(old, mask, set).
- No sub-module: the port mux, FSM and forward registers stay in one block.
- Instantiated next to cheri_trvk_stage. Its tsmap_cs_o/tsmap_addr_o feed trvk_cs_i/trvk_addr_i, and trvk_rdata_o feeds back to tsmap_rdata_i.

## Test plan
- Uncontended set: word 5 = 0x0000_00F0; update addr 5, mask 0x0000_000F, set=1 -> write 0x0000_00FF at t+3, done at t+4, err=0.
- Deferral: trvk_cs_i held high for 3 cycles while the FSM is in RD.
  - Required: read issued only after trvk_cs_i drops; done at t+7.
  - Every lookup in that window returns data at +1.
- Forwarding: word 9 = 0xFFFF_FFFF; clear with mask 0x0000_0001; lookup of addr 9 in the CAP cycle and again in the WR cycle (trvk blocks the write).
  - Required: trvk_rdata_o = 0xFFFF_FFFE both times.
  - Subsequent memory reads also return 0xFFFF_FFFE after the write.
- Non-colliding lookup during WR, addr 3 with word 3 = 0x1234_5678 -> trvk_rdata_o = 0x1234_5678; the write is deferred one cycle.
- Out of range: update addr = TSMapSize -> done+err at t+1; mem_req_o stays 0.
- Reset asserted in WR -> no SRAM write, no done; all outputs at reset values; a fresh update afterwards completes normally.

Source files
------------

// File: rtl/cheri_pkg.sv
// cheri_pkg
//   Shared definitions for the CHERI revocation blocks.
//   - tsmap_ctrl_state_e : states of the TSMAP SRAM controller FSM
//   - tsmap_merge()      : applies a set/clear bit mask to a TSMAP word
package cheri_pkg;

  typedef enum logic [1:0] {
    TSMAP_IDLE = 2'd0,
    TSMAP_RD   = 2'd1,
    TSMAP_CAP  = 2'd2,
    TSMAP_WR   = 2'd3
  } tsmap_ctrl_state_e;

  // Set (isSet=1) or clear (isSet=0) the bits selected by bitMask.
  function automatic logic [31:0] tsmap_merge(input logic [31:0] oldWord,
                                              input logic [31:0] bitMask,
                                              input logic        isSet);
    return isSet ? (oldWord | bitMask) : (oldWord & ~bitMask);
  endfunction

endpackage

// File: rtl/cheri_tsmap_ctrl.sv
// cheri_tsmap_ctrl
//   Single-port controller for the revocation bitmap (TSMAP) SRAM.
//   Revocation lookups own the port whenever they strobe and always get
//   their data one cycle later. Allocator bit set/clear updates run as
//   read-modify-write sequences in the idle slots between lookups, and a
//   lookup that hits the word being updated receives the merged value.
//
//   Ports
//     clk_i, rst_ni         clock, asynchronous active-low reset
//     trvk_cs_i/addr_i      lookup strobe and word address
//     trvk_rdata_o          lookup data, one cycle after the strobe
//     upd_req_i/gnt_o       update handshake (grant is combinational)
//     upd_addr_i/mask_i     update word address and bits to modify
//     upd_set_i             1 = set masked bits, 0 = clear them
//     upd_done_o/err_o      completion pulse, err = address out of range
//     busy_o                an update is in flight
//     mem_*                 single-port SRAM interface, 1-cycle read latency
module cheri_tsmap_ctrl
  import cheri_pkg::*;
#(
  parameter int unsigned TSMapSize = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trvk_cs_i,
  input  logic [15:0] trvk_addr_i,
  output logic [31:0] trvk_rdata_o,
  input  logic        upd_req_i,
  output logic        upd_gnt_o,
  input  logic [15:0] upd_addr_i,
  input  logic [31:0] upd_mask_i,
  input  logic        upd_set_i,
  output logic        upd_done_o,
  output logic        upd_err_o,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  tsmap_ctrl_state_e r_state, w_stateNext;

  logic [15:0] r_addr;
  logic [31:0] r_mask;
  logic        r_set;
  logic [31:0] r_fwdData;
  logic        r_fwdSel;
  logic        r_done;
  logic        r_err;

  logic        w_inRange;
  logic        w_latch;
  logic        w_doneNext;
  logic        w_errNext;
  logic        w_collide;
  logic [31:0] w_merged;

  assign w_inRange = ({16'd0, upd_addr_i} < TSMapSize);

  // In CAP the SRAM read data of the update is on mem_rdata_i this cycle.
  assign w_merged = tsmap_merge(mem_rdata_i, r_mask, r_set);

  // Once the old word has been captured, lookups of the same word must see
  // the merged value; before that (RD) plain memory data is still correct.
  assign w_collide = trvk_cs_i && (trvk_addr_i == r_addr) &&
                     ((r_state == TSMAP_CAP) || (r_state == TSMAP_WR));

  // Next-state logic and SRAM port mux; a lookup overrides any FSM access.
  always_comb begin
    w_stateNext = r_state;
    upd_gnt_o   = 1'b0;
    w_latch     = 1'b0;
    w_doneNext  = 1'b0;
    w_errNext   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 16'd0;
    mem_wdata_o = 32'd0;

    unique case (r_state)
      TSMAP_IDLE: begin
        upd_gnt_o = upd_req_i;
        if (upd_req_i) begin
          w_latch = 1'b1;
          if (w_inRange) begin
            w_stateNext = TSMAP_RD;
          end else begin
            w_doneNext = 1'b1;
            w_errNext  = 1'b1;
          end
        end
      end
      TSMAP_RD: begin
        if (!trvk_cs_i) begin
          mem_req_o   = 1'b1;
          mem_addr_o  = r_addr;
          w_stateNext = TSMAP_CAP;
        end
      end
      TSMAP_CAP: begin
        w_stateNext = TSMAP_WR;
      end
      TSMAP_WR: begin
        if (!trvk_cs_i) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = r_addr;
          mem_wdata_o = r_fwdData;
          w_doneNext  = 1'b1;
          w_stateNext = TSMAP_IDLE;
        end
      end
      default: w_stateNext = TSMAP_IDLE;
    endcase

    if (trvk_cs_i) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b0;
      mem_addr_o  = trvk_addr_i;
      mem_wdata_o = 32'd0;
    end
  end

  // State, latched request, merged word and forward/completion flags.
  // Reset drops any in-flight update without writing it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= TSMAP_IDLE;
      r_addr    <= 16'd0;
      r_mask    <= 32'd0;
      r_set     <= 1'b0;
      r_fwdData <= 32'd0;
      r_fwdSel  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_latch) begin
        r_addr <= upd_addr_i;
        r_mask <= upd_mask_i;
        r_set  <= upd_set_i;
      end
      if (r_state == TSMAP_CAP) begin
        r_fwdData <= w_merged;
      end
      r_fwdSel <= w_collide;
      r_done   <= w_doneNext;
      r_err    <= w_errNext;
    end
  end

  assign trvk_rdata_o = r_fwdSel ? r_fwdData : mem_rdata_i;
  assign upd_done_o   = r_done;
  assign upd_err_o    = r_err;
  assign busy_o       = (r_state != TSMAP_IDLE);

endmodule

// File: tb/tb_cheri_tsmap_ctrl.sv
// tb_cheri_tsmap_ctrl
//   Bench for cheri_tsmap_ctrl: a behavioural SRAM, a transaction-level
//   model of the update/lookup rules checked every cycle, and directed
//   scenarios with hand-computed expectations.
module tb_cheri_tsmap_ctrl;

  localparam int unsigned TSMapSize = 1024;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        trvk_cs_i;
  logic [15:0] trvk_addr_i;
  logic [31:0] trvk_rdata_o;
  logic        upd_req_i;
  logic        upd_gnt_o;
  logic [15:0] upd_addr_i;
  logic [31:0] upd_mask_i;
  logic        upd_set_i;
  logic        upd_done_o;
  logic        upd_err_o;
  logic        busy_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'd0;

  int total = 0;
  int bad   = 0;

  logic [31:0] sram   [0:1023];
  logic [31:0] golden [0:1023];

  cheri_tsmap_ctrl #(.TSMapSize(TSMapSize)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .trvk_cs_i   (trvk_cs_i),
    .trvk_addr_i (trvk_addr_i),
    .trvk_rdata_o(trvk_rdata_o),
    .upd_req_i   (upd_req_i),
    .upd_gnt_o   (upd_gnt_o),
    .upd_addr_i  (upd_addr_i),
    .upd_mask_i  (upd_mask_i),
    .upd_set_i   (upd_set_i),
    .upd_done_o  (upd_done_o),
    .upd_err_o   (upd_err_o),
    .busy_o      (busy_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Single-port SRAM, read data one cycle after a read strobe.
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) sram[mem_addr_o[9:0]] <= mem_wdata_o;
      else          mem_rdata_i <= sram[mem_addr_o[9:0]];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic [15:0] caddr, input logic req,
                               input logic [15:0] uaddr, input logic [31:0] mask, input logic set);
    trvk_cs_i   = cs;
    trvk_addr_i = caddr;
    upd_req_i   = req;
    upd_addr_i  = uaddr;
    upd_mask_i  = mask;
    upd_set_i   = set;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Reference model. An update goes through: waiting for a free read slot,
  // the capture cycle (from here on lookups of that word see the new
  // value), waiting for a free write slot, then done one cycle later.
  // golden[] is the logical bitmap content after committed updates.
  // ---------------------------------------------------------------------
  int          mPhase = 0;
  logic [15:0] pAddr;
  logic [31:0] pMask;
  logic        pSet;
  logic [31:0] mMerged;
  logic        mDone = 1'b0;
  logic        mErr  = 1'b0;
  logic        prevCs = 1'b0;
  logic [31:0] prevExp;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mPhase = 0;
      mDone  = 1'b0;
      mErr   = 1'b0;
      prevCs = 1'b0;
      checkOutput("rst_done", upd_done_o, 0);
      checkOutput("rst_err", upd_err_o, 0);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_memreq", mem_req_o, 0);
      checkOutput("rst_rdata", trvk_rdata_o, mem_rdata_i);
    end else begin
      if (prevCs) checkOutput("lookup_data", trvk_rdata_o, prevExp);
      checkOutput("m_gnt", upd_gnt_o, (mPhase == 0) && upd_req_i);
      checkOutput("m_busy", busy_o, mPhase != 0);
      checkOutput("m_done", upd_done_o, mDone);
      checkOutput("m_err", upd_err_o, mErr);
      if (trvk_cs_i) begin
        checkOutput("m_lk_req", mem_req_o, 1);
        checkOutput("m_lk_we", mem_we_o, 0);
        checkOutput("m_lk_addr", mem_addr_o, trvk_addr_i);
      end else if (mPhase == 1) begin
        checkOutput("m_rd_req", mem_req_o, 1);
        checkOutput("m_rd_we", mem_we_o, 0);
        checkOutput("m_rd_addr", mem_addr_o, pAddr);
      end else if (mPhase == 3) begin
        checkOutput("m_wr_req", mem_req_o, 1);
        checkOutput("m_wr_we", mem_we_o, 1);
        checkOutput("m_wr_addr", mem_addr_o, pAddr);
        checkOutput("m_wr_data", mem_wdata_o, mMerged);
      end else begin
        checkOutput("m_noreq", mem_req_o, 0);
      end

      prevCs = trvk_cs_i;
      if ((mPhase == 2 || mPhase == 3) && trvk_addr_i == pAddr) prevExp = mMerged;
      else prevExp = golden[trvk_addr_i[9:0]];

      mDone = 1'b0;
      mErr  = 1'b0;
      case (mPhase)
        0: if (upd_req_i) begin
          if (upd_addr_i >= TSMapSize) begin
            mDone = 1'b1;
            mErr  = 1'b1;
          end else begin
            pAddr  = upd_addr_i;
            pMask  = upd_mask_i;
            pSet   = upd_set_i;
            mPhase = 1;
          end
        end
        1: if (!trvk_cs_i) begin
          mMerged = pSet ? (golden[pAddr[9:0]] | pMask) : (golden[pAddr[9:0]] & ~pMask);
          mPhase  = 2;
        end
        2: mPhase = 3;
        default: if (!trvk_cs_i) begin
          golden[pAddr[9:0]] = mMerged;
          mDone  = 1'b1;
          mPhase = 0;
        end
      endcase
    end
  end

  // Request an update and wait (bounded) for its done pulse.
  task automatic runUpdate(input logic [15:0] addr, input logic [31:0] mask,
                           input logic set, input logic expErr);
    bit seen = 0;
    applyStimulus(0, 0, 1, addr, mask, set);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk_i);
      if (upd_done_o) seen = 1;
    end
    checkOutput("upd_completed", seen, 1);
    if (seen) checkOutput("upd_err_flag", upd_err_o, expErr);
    tick();
  endtask

  task automatic lookupCheck(input string name, input logic [15:0] addr, input logic [31:0] exp);
    applyStimulus(1, addr, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput(name, trvk_rdata_o, exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]   = 32'd0;
      golden[i] = 32'd0;
    end
    sram[3] = 32'h1234_5678; golden[3] = 32'h1234_5678;
    sram[5] = 32'h0000_00F0; golden[5] = 32'h0000_00F0;
    sram[9] = 32'hFFFF_FFFF; golden[9] = 32'hFFFF_FFFF;

    rst_ni = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Uncontended set on word 5
    $display("[TB] uncontended set");
    applyStimulus(0, 0, 1, 16'd5, 32'h0000_000F, 1);
    @(negedge clk_i); checkOutput("t1_gnt", upd_gnt_o, 1);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("t1_rd_req", mem_req_o, 1);
    checkOutput("t1_rd_we", mem_we_o, 0);
    checkOutput("t1_rd_addr", mem_addr_o, 16'd5);
    tick(); @(negedge clk_i);
    checkOutput("t1_cap_idle", mem_req_o, 0);
    checkOutput("t1_cap_busy", busy_o, 1);
    tick(); @(negedge clk_i);
    checkOutput("t1_wr_we", mem_we_o, 1);
    checkOutput("t1_wr_data", mem_wdata_o, 32'h0000_00FF);
    tick(); @(negedge clk_i);
    checkOutput("t1_done", upd_done_o, 1);
    checkOutput("t1_err", upd_err_o, 0);
    tick();
    lookupCheck("t1_readback", 16'd5, 32'h0000_00FF);

    // Deferral: lookups during RD push the read out
    $display("[TB] deferral");
    applyStimulus(0, 0, 1, 16'd7, 32'h0000_0003, 1);
    tick(); applyStimulus(1, 16'd3, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("t2_defer_addr", mem_addr_o, 16'd3);
    checkOutput("t2_defer_we", mem_we_o, 0);
    tick(); applyStimulus(1, 16'd5, 0, 0, 0, 0);
    @(negedge clk_i); checkOutput("t2_lk3", trvk_rdata_o, 32'h1234_5678);
    tick(); applyStimulus(1, 16'd9, 0, 0, 0, 0);
    @(negedge clk_i); checkOutput("t2_lk5", trvk_rdata_o, 32'h0000_00FF);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("t2_lk9", trvk_rdata_o, 32'hFFFF_FFFF);
    checkOutput("t2_rd_req", mem_req_o, 1);
    checkOutput("t2_rd_addr", mem_addr_o, 16'd7);
    tick(); tick(); tick();
    @(negedge clk_i); checkOutput("t2_done_t7", upd_done_o, 1);
    tick();

    // Forwarding to colliding lookups in CAP and WR
    $display("[TB] forwarding");
    applyStimulus(0, 0, 1, 16'd9, 32'h0000_0001, 0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    tick(); applyStimulus(1, 16'd9, 0, 0, 0, 0);
    tick(); applyStimulus(1, 16'd9, 0, 0, 0, 0);
    @(negedge clk_i); checkOutput("t3_fwd_cap", trvk_rdata_o, 32'hFFFF_FFFE);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("t3_fwd_wr", trvk_rdata_o, 32'hFFFF_FFFE);
    checkOutput("t3_wr_we", mem_we_o, 1);
    checkOutput("t3_wr_data", mem_wdata_o, 32'hFFFF_FFFE);
    tick(); @(negedge clk_i); checkOutput("t3_done", upd_done_o, 1);
    tick();
    lookupCheck("t3_readback", 16'd9, 32'hFFFF_FFFE);

    // Non-colliding lookup during WR
    $display("[TB] lookup during write");
    applyStimulus(0, 0, 1, 16'd4, 32'h0000_0100, 1);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick(); applyStimulus(1, 16'd3, 0, 0, 0, 0);
    @(negedge clk_i); checkOutput("t4_wr_blocked", mem_we_o, 0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("t4_lk3", trvk_rdata_o, 32'h1234_5678);
    checkOutput("t4_wr_we", mem_we_o, 1);
    checkOutput("t4_wr_data", mem_wdata_o, 32'h0000_0100);
    tick(); @(negedge clk_i); checkOutput("t4_done", upd_done_o, 1);
    tick();

    // Out of range and top legal address
    $display("[TB] address range");
    applyStimulus(0, 0, 1, 16'd1024, 32'h0000_0001, 1);
    @(negedge clk_i);
    checkOutput("t5_gnt", upd_gnt_o, 1);
    checkOutput("t5_noreq0", mem_req_o, 0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("t5_done", upd_done_o, 1);
    checkOutput("t5_err", upd_err_o, 1);
    checkOutput("t5_noreq1", mem_req_o, 0);
    checkOutput("t5_busy", busy_o, 0);
    tick();
    runUpdate(16'd1023, 32'h8000_0000, 1, 0);
    lookupCheck("t5_top_word", 16'd1023, 32'h8000_0000);
    runUpdate(16'd5, 32'h0000_0000, 0, 0);
    lookupCheck("t5_zero_mask", 16'd5, 32'h0000_00FF);

    // Reset while holding in WR
    $display("[TB] reset mid-update");
    applyStimulus(0, 0, 1, 16'd5, 32'h0000_0F00, 1);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick(); applyStimulus(1, 16'd0, 0, 0, 0, 0);
    @(negedge clk_i); checkOutput("t6_busy_wr", busy_o, 1);
    #1;
    rst_ni = 1'b0;
    applyStimulus(0, 0, 1, 16'd5, 0, 0);
    #1;
    checkOutput("t6_rst_busy", busy_o, 0);
    checkOutput("t6_rst_done", upd_done_o, 0);
    checkOutput("t6_rst_err", upd_err_o, 0);
    checkOutput("t6_rst_req", mem_req_o, 0);
    checkOutput("t6_rst_we", mem_we_o, 0);
    checkOutput("t6_rst_addr", mem_addr_o, 0);
    checkOutput("t6_rst_wdata", mem_wdata_o, 0);
    checkOutput("t6_rst_gnt", upd_gnt_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    checkOutput("t6_no_write", sram[5], 32'h0000_00FF);
    tick();
    lookupCheck("t6_lost", 16'd5, 32'h0000_00FF);
    runUpdate(16'd5, 32'h0000_0F00, 1, 0);
    lookupCheck("t6_retry", 16'd5, 32'h0000_0FFF);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
